// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam logic [7:0] DEF_PAT = 8'b0011_1010;
  localparam logic       OVL_ON  = 1'b1;
  localparam logic       OVL_OFF = 1'b0;

  function automatic int clog2_len(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream, configuration and status bundle of the sequence detector.
interface seq_detect_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = seq_det_pkg::clog2_len(PAT_W);

  logic             in_valid;
  logic             in;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             cnt_clr;
  logic             out;
  logic [LEN_W-1:0] state;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output in_valid, in, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
    input  out, state, match_cnt, cnt_sat
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
    output out, state, match_cnt, cnt_sat
  );

endinterface

// File: rtl/seq_det_next.sv
// Combinational next matched-prefix length: extends on the expected bit,
// otherwise falls back to the longest received tail that is a pattern prefix.
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 8,
  localparam int LEN_W = clog2_len(PAT_W)
) (
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] state,
  input  logic             in,
  output logic [LEN_W-1:0] next_state,
  output logic             hit
);
  localparam int IDX_W = $clog2(PAT_W);

  function automatic logic pat_bit(input logic [PAT_W-1:0] p, input int idx);
    logic b;
    if (idx >= 0 && idx < PAT_W) b = p[IDX_W'(idx)];
    else                         b = 1'b0;
    return b;
  endfunction

  // Candidate k aligns pattern prefix k with the last k bits of (prefix[state], in); longest wins.
  always_comb begin
    logic ok_s;
    logic found_s;
    logic got_s;
    int   len_i;
    int   st_i;
    int   j;
    next_state = '0;
    found_s    = 1'b0;
    got_s      = 1'b0;
    ok_s       = 1'b0;
    j          = 0;
    len_i      = int'(len);
    st_i       = int'(state);
    for (int k = PAT_W; k >= 1; k--) begin
      ok_s = (k <= st_i + 1) && (k <= len_i);
      for (int i = 0; i < PAT_W; i++) begin
        j     = st_i + 1 - k + i;
        got_s = (j == st_i) ? in : pat_bit(pat, len_i - 1 - j);
        ok_s  = ok_s & ((i >= k) | (pat_bit(pat, len_i - 1 - i) == got_s));
      end
      next_state = (ok_s && !found_s) ? LEN_W'(k) : next_state;
      found_s    = found_s | ok_s;
    end
    hit = found_s && (next_state == len);
  end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial sequence detector with overlap control and a
// saturating match counter; holds config, state, pulse and counter registers.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT),
  parameter int               RST_LEN = PAT_W
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam int               LEN_W     = clog2_len(PAT_W);
  localparam int               IDX_W     = $clog2(PAT_W);
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN_C = (RST_LEN < 1 || RST_LEN > PAT_W) ? FULL_LEN : LEN_W'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [LEN_W-1:0] state_r;
  logic             out_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  logic [LEN_W-1:0] fall_state_s;
  logic [LEN_W-1:0] border_s;
  logic [LEN_W-1:0] cfg_len_s;
  logic [LEN_W-1:0] state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             hit_s;
  logic             match_s;

  seq_det_next #(.PAT_W(PAT_W)) u_next (
    .pat        (pat_r),
    .len        (len_r),
    .state      (state_r),
    .in         (bus.in),
    .next_state (fall_state_s),
    .hit        (hit_s)
  );

  function automatic logic pat_bit(input logic [PAT_W-1:0] p, input int idx);
    logic b;
    if (idx >= 0 && idx < PAT_W) b = p[IDX_W'(idx)];
    else                         b = 1'b0;
    return b;
  endfunction

  assign match_s = bus.in_valid & ~bus.cfg_load & hit_s;

  // Longest proper border of the active pattern: restart point after an overlapping match.
  always_comb begin
    logic ok_s;
    int   len_i;
    border_s = '0;
    ok_s     = 1'b0;
    len_i    = int'(len_r);
    for (int k = 1; k < PAT_W; k++) begin
      ok_s = (k < len_i);
      for (int i = 0; i < PAT_W; i++) begin
        ok_s = ok_s & ((i >= k) | (pat_bit(pat_r, len_i - 1 - i) == pat_bit(pat_r, k - 1 - i)));
      end
      border_s = ok_s ? LEN_W'(k) : border_s;
    end
  end

  // Out-of-range lengths fall back to the full pattern width.
  always_comb begin
    if (bus.cfg_len == '0 || int'(bus.cfg_len) > PAT_W) cfg_len_s = FULL_LEN;
    else                                                cfg_len_s = bus.cfg_len;
  end

  // Next matched-prefix length.
  always_comb begin
    if (bus.cfg_load)         state_nxt_s = '0;
    else if (!bus.in_valid)   state_nxt_s = state_r;
    else if (hit_s)           state_nxt_s = (ovl_r == OVL_OFF) ? '0 : border_s;
    else                      state_nxt_s = fall_state_s;
  end

  // Saturating counter; a clear coinciding with a match keeps that match.
  always_comb begin
    if (bus.cnt_clr)                       cnt_nxt_s = match_s ? CNT_W'(1) : '0;
    else if (match_s && cnt_r != CNT_MAX)  cnt_nxt_s = cnt_r + CNT_W'(1);
    else                                   cnt_nxt_s = cnt_r;
  end

  // Config, state, pulse and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_r   <= RST_PAT;
      len_r   <= RST_LEN_C;
      ovl_r   <= OVL_ON;
      state_r <= '0;
      out_r   <= 1'b0;
      cnt_r   <= '0;
      sat_r   <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        pat_r <= bus.cfg_pat;
        len_r <= cfg_len_s;
        ovl_r <= bus.cfg_ovl;
      end else begin
        pat_r <= pat_r;
        len_r <= len_r;
        ovl_r <= ovl_r;
      end
      state_r <= state_nxt_s;
      out_r   <= match_s;
      cnt_r   <= cnt_nxt_s;
      sat_r   <= (cnt_nxt_s == CNT_MAX);
    end
  end

  assign bus.out       = out_r;
  assign bus.state     = state_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cnt_sat   = sat_r;

endmodule
